// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Shared types for the immediate-generation stage: format
//               codes, RV32I/RV64I major opcodes, the buffered entry record
//               and an extension helper.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

  // Entry fields are sized for the widest legal XLEN. Narrower builds use
  // the low XLEN bits and keep the upper bits at zero.
  localparam int IMM_XLEN_MAX = 64;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [IMM_XLEN_MAX-1:0] imm;
    imm_fmt_e                fmt;
    logic [IMM_XLEN_MAX-1:0] target;
    logic [IMM_XLEN_MAX-1:0] pc;
    logic                    illegal;
  } imm_entry_t;

  // Extend the low w bits of v to the full entry width, replicating bit
  // w-1 when sgn is set and filling with zeros otherwise.
  function automatic logic [IMM_XLEN_MAX-1:0] ext_bits(
    input logic [IMM_XLEN_MAX-1:0] v,
    input int unsigned             w,
    input logic                    sgn
  );
    logic [IMM_XLEN_MAX-1:0] r;
    r = v;
    for (int i = 0; i < IMM_XLEN_MAX; i++) begin
      if (i >= int'(w)) begin
        r[i] = sgn ? v[w-1] : 1'b0;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Combinational immediate decoder. Extracts the immediate of
//               every base-ISA format, extends it to XLEN and precomputes
//               pc + imm.
// Ports       : i_instr  - raw 32-bit instruction word
//               i_pc     - PC of i_instr (XLEN bits)
//               o_entry  - decoded {imm, fmt, target, pc, illegal}
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int SIGN_EXT = 1,
  parameter int SHAMT_W  = 5
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output imm_entry_t      o_entry
);

  localparam logic c_sgn = (SIGN_EXT != 0);

  logic [6:0]              w_opc;
  logic [2:0]              w_f3;
  logic [IMM_XLEN_MAX-1:0] w_imm64;
  imm_fmt_e                w_fmt;
  logic                    w_ill;
  logic [XLEN-1:0]         w_imm;
  logic [XLEN-1:0]         w_target;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];

  always_comb begin
    w_imm64 = '0;
    w_fmt   = FMT_NONE;
    w_ill   = 1'b0;
    case (w_opc)
      OPC_OPIMM: begin
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          // Shift amount only; funct7/funct6 above it never leak in.
          w_imm64 = 64'(i_instr[20 +: SHAMT_W]);
          w_fmt   = FMT_SHAMT;
        end else begin
          w_imm64 = ext_bits(64'(i_instr[31:20]), 12, c_sgn);
          w_fmt   = FMT_I;
        end
      end
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        w_imm64 = ext_bits(64'(i_instr[31:20]), 12, c_sgn);
        w_fmt   = FMT_I;
      end
      OPC_STORE: begin
        w_imm64 = ext_bits(64'({i_instr[31:25], i_instr[11:7]}), 12, c_sgn);
        w_fmt   = FMT_S;
      end
      OPC_BRANCH: begin
        w_imm64 = ext_bits(64'({i_instr[31], i_instr[7], i_instr[30:25],
                                i_instr[11:8], 1'b0}), 13, c_sgn);
        w_fmt   = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        // The upper word is always a sign copy, even in zero-extend mode,
        // so RV64 LUI/AUIPC keep their architectural meaning.
        w_imm64 = {{32{i_instr[31]}}, i_instr[31:12], 12'h000};
        w_fmt   = FMT_U;
      end
      OPC_JAL: begin
        w_imm64 = ext_bits(64'({i_instr[31], i_instr[19:12], i_instr[20],
                                i_instr[30:21], 1'b0}), 21, c_sgn);
        w_fmt   = FMT_J;
      end
      OPC_OP: begin
        w_fmt = FMT_NONE;
      end
      default: begin
        w_ill = 1'b1;
      end
    endcase
  end

  assign w_imm    = w_imm64[XLEN-1:0];
  assign w_target = i_pc + w_imm;

  always_comb begin
    o_entry         = '0;
    o_entry.imm     = 64'(w_imm);
    o_entry.fmt     = w_fmt;
    o_entry.target  = 64'(w_target);
    o_entry.pc      = 64'(i_pc);
    o_entry.illegal = w_ill;
  end

  generate
    if (XLEN < IMM_XLEN_MAX) begin : g_narrow
      // Upper bits of the wide extension are meaningless in a narrow build.
      logic w_unused_hi;
      assign w_unused_hi = ^w_imm64[IMM_XLEN_MAX-1:XLEN];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_stage
// Description : Registered immediate-generation stage with valid/ready
//               handshake and a 2-entry skid buffer. Decode happens before
//               the buffer write; the head entry drives the outputs.
// Ports       : clk, rst                     - clock, sync active-high reset
//               in_valid/in_ready            - upstream handshake
//               in_instr, in_pc              - instruction and its PC
//               out_valid/out_ready          - downstream handshake
//               out_imm, out_fmt, out_target - decoded immediate, format,
//                                              pc + imm
//               out_pc, out_illegal          - PC passthrough, bad opcode
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int SIGN_EXT = 1,
  parameter int SHAMT_W  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  imm_entry_t w_dec;
  imm_entry_t r_e0;   // head (oldest) entry, drives the outputs
  imm_entry_t r_e1;   // second entry, only valid in FULL
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_in_ready;
  logic       w_in_xfer;
  logic       w_out_xfer;
  logic       w_out_valid;

  imm_decode #(
    .XLEN     (XLEN),
    .SIGN_EXT (SIGN_EXT),
    .SHAMT_W  (SHAMT_W)
  ) u_decode (
    .i_instr (in_instr),
    .i_pc    (in_pc),
    .o_entry (w_dec)
  );

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_xfer   = in_valid && r_in_ready;
  assign w_out_xfer  = w_out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_in_xfer) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_in_xfer && !w_out_xfer)      w_state_nxt = ST_FULL;
        else if (!w_in_xfer && w_out_xfer) w_state_nxt = ST_EMPTY;
      end
      ST_FULL: if (w_out_xfer) w_state_nxt = ST_ONE;
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_e0       <= '0;
      r_e1       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      // Registered from the next state so out_ready never reaches in_ready
      // through logic.
      r_in_ready <= (w_state_nxt != ST_FULL);
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) r_e0 <= w_dec;
        end
        ST_ONE: begin
          if (w_in_xfer && !w_out_xfer)     r_e1 <= w_dec;
          else if (w_in_xfer && w_out_xfer) r_e0 <= w_dec;
        end
        ST_FULL: begin
          if (w_out_xfer) r_e0 <= r_e1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = w_out_valid;
  assign out_imm     = r_e0.imm[XLEN-1:0];
  assign out_fmt     = r_e0.fmt;
  assign out_target  = r_e0.target[XLEN-1:0];
  assign out_pc      = r_e0.pc[XLEN-1:0];
  assign out_illegal = r_e0.illegal;

  generate
    if (XLEN < IMM_XLEN_MAX) begin : g_narrow
      logic w_unused_hi;
      assign w_unused_hi = ^{r_e0.imm[IMM_XLEN_MAX-1:XLEN],
                             r_e0.target[IMM_XLEN_MAX-1:XLEN],
                             r_e0.pc[IMM_XLEN_MAX-1:XLEN]};
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_stage
// Description : Directed self-checking bench for imm_gen_stage. One RV32
//               sign-extending instance and one RV64 zero-extending instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_stage;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm, out_target, out_pc;
  logic [2:0]  out_fmt;

  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_illegal;
  logic [31:0] d_in_instr;
  logic [63:0] d_in_pc, d_out_imm, d_out_target, d_out_pc;
  logic [2:0]  d_out_fmt;

  imm_gen_stage #(.XLEN(32), .SIGN_EXT(1), .SHAMT_W(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_target(out_target), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  imm_gen_stage #(.XLEN(64), .SIGN_EXT(0), .SHAMT_W(6)) dut64 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_instr(d_in_instr), .in_pc(d_in_pc), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_imm(d_out_imm), .out_fmt(d_out_fmt),
    .out_target(d_out_target), .out_pc(d_out_pc), .out_illegal(d_out_illegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tgt;
    logic        ill;
  } vec_t;

  vec_t vt[14];

  // Per-cycle handshake bookkeeping for the streaming sequences.
  int          acc;
  int          ngot;
  logic [31:0] got_pc[8];
  logic [31:0] got_imm[8];
  logic        s_rdy, s_ov;
  logic [31:0] s_pc, s_imm;

  task automatic tick();
    @(negedge clk);
    s_rdy = in_ready;
    s_ov  = out_valid;
    s_pc  = out_pc;
    s_imm = out_imm;
    @(posedge clk);
    if (in_valid && s_rdy) acc++;
    if (s_ov && out_ready) begin
      if (ngot < 8) begin
        got_pc[ngot]  = s_pc;
        got_imm[ngot] = s_imm;
      end
      ngot++;
    end
    #1;
  endtask

  function automatic logic [31:0] mk_addi(input int k);
    logic [11:0] im;
    im = 12'(k + 1);
    return {im, 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  task automatic drive(input int k, input logic [31:0] base);
    in_instr = mk_addi(k);
    in_pc    = base + 32'(4 * k);
  endtask

  task automatic run64(input string nm, input logic [31:0] ins, input logic [63:0] pc,
                       input logic [63:0] eimm, input logic [2:0] efmt,
                       input logic [63:0] etgt);
    d_in_valid = 1'b1;
    d_in_instr = ins;
    d_in_pc    = pc;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 64'(d_out_valid), 64'd1);
    chk({nm, "_imm"}, d_out_imm, eimm);
    chk({nm, "_fmt"}, 64'(d_out_fmt), 64'(efmt));
    chk({nm, "_target"}, d_out_target, etgt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{32'hFFF00093, 32'h1000, 32'hFFFFFFFF, FMT_I,     32'h00000FFF, 1'b0};
    vt[1]  = '{32'hFE112E23, 32'h1000, 32'hFFFFFFFC, FMT_S,     32'h00000FFC, 1'b0};
    vt[2]  = '{32'hFE000CE3, 32'h1000, 32'hFFFFFFF8, FMT_B,     32'h00000FF8, 1'b0};
    vt[3]  = '{32'h123450B7, 32'h1000, 32'h12345000, FMT_U,     32'h12346000, 1'b0};
    vt[4]  = '{32'h0080006F, 32'h1000, 32'h00000008, FMT_J,     32'h00001008, 1'b0};
    vt[5]  = '{32'h00509093, 32'h1000, 32'h00000005, FMT_SHAMT, 32'h00001005, 1'b0};
    vt[6]  = '{32'h4030D093, 32'h1000, 32'h00000003, FMT_SHAMT, 32'h00001003, 1'b0};
    vt[7]  = '{32'h0000007F, 32'h1000, 32'h00000000, FMT_NONE,  32'h00001000, 1'b1};
    vt[8]  = '{32'h002081B3, 32'h1000, 32'h00000000, FMT_NONE,  32'h00001000, 1'b0};
    vt[9]  = '{32'h00812083, 32'h1000, 32'h00000008, FMT_I,     32'h00001008, 1'b0};
    vt[10] = '{32'h7FF08067, 32'h1000, 32'h000007FF, FMT_I,     32'h000017FF, 1'b0};
    vt[11] = '{32'h00000073, 32'h1000, 32'h00000000, FMT_I,     32'h00001000, 1'b0};
    vt[12] = '{32'h0080006F, 32'hFFFFFFFC, 32'h00000008, FMT_J, 32'h00000004, 1'b0};
    vt[13] = '{32'h800000B7, 32'h1000, 32'h80000000, FMT_U,     32'h80001000, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; in_instr = '0; in_pc = '0;
    d_in_valid = 1'b0; d_out_ready = 1'b1; d_in_instr = '0; d_in_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_target", 64'(out_target), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_fmt", 64'(out_fmt), 64'd0);
    chk("rst_illegal", 64'(out_illegal), 64'd0);
    @(posedge clk);
    #1;

    // Format table: one instruction at a time, out_ready held high
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      in_instr = vt[i].instr;
      in_pc    = vt[i].pc;
      @(negedge clk);
      chk($sformatf("v%0d_pre_valid", i), 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_imm", i), 64'(out_imm), 64'(vt[i].imm));
      chk($sformatf("v%0d_fmt", i), 64'(out_fmt), 64'(vt[i].fmt));
      chk($sformatf("v%0d_target", i), 64'(out_target), 64'(vt[i].tgt));
      chk($sformatf("v%0d_pc", i), 64'(out_pc), 64'(vt[i].pc));
      chk($sformatf("v%0d_illegal", i), 64'(out_illegal), 64'(vt[i].ill));
      @(posedge clk);
      #1;
    end

    // Backpressure: four offered with out_ready low, only two fit
    out_ready = 1'b0;
    acc = 0; ngot = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      drive(acc, 32'h2000);
      tick();
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_pc", 64'(out_pc), 64'h2000);
    chk("bp_hold_imm", 64'(out_imm), 64'd1);
    chk("bp_none_out", 64'(ngot), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && ngot < 4; c++) begin
      in_valid = (acc < 4);
      drive(acc, 32'h2000);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(ngot), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_order_pc%0d", k), 64'(got_pc[k]), 64'(32'h2000 + 32'(4 * k)));
      chk($sformatf("bp_order_imm%0d", k), 64'(got_imm[k]), 64'(k + 1));
    end
    tick();
    chk("bp_no_dup", 64'(ngot), 64'd4);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Simultaneous in/out transfer while holding one entry
    acc = 0; ngot = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(0, 32'h3000);
    tick();
    drive(1, 32'h3000);
    tick();
    in_valid = 1'b0;
    chk("sim_popped", 64'(ngot), 64'd1);
    chk("sim_old_pc", 64'(got_pc[0]), 64'h3000);
    chk("sim_valid", 64'(out_valid), 64'd1);
    chk("sim_new_pc", 64'(out_pc), 64'h3004);
    chk("sim_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("sim_drain", 64'(ngot), 64'd2);

    // Reset while FULL, with an input offered during reset
    acc = 0; ngot = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(0, 32'h4000);
    tick();
    drive(1, 32'h4000);
    tick();
    chk("rf_full", 64'(in_ready), 64'd0);
    drive(2, 32'h4000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rf_out_valid", 64'(out_valid), 64'd0);
    chk("rf_in_ready", 64'(in_ready), 64'd1);
    chk("rf_imm", 64'(out_imm), 64'd0);
    chk("rf_target", 64'(out_target), 64'd0);
    chk("rf_pc", 64'(out_pc), 64'd0);
    chk("rf_fmt", 64'(out_fmt), 64'd0);
    chk("rf_illegal", 64'(out_illegal), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    ngot = 0;
    repeat (3) tick();
    chk("rf_no_ghost", 64'(ngot), 64'd0);

    // RV64, zero-extend mode
    run64("x64_addi", 32'hFFF00093, 64'hFFFFFFFFFFFFF001, 64'h0000000000000FFF,
          FMT_I, 64'h0);
    run64("x64_lui", 32'h800000B7, 64'h0, 64'hFFFFFFFF80000000, FMT_U,
          64'hFFFFFFFF80000000);
    run64("x64_slli63", 32'h03F09093, 64'h100, 64'd63, FMT_SHAMT, 64'h13F);
    run64("x64_sw", 32'hFE112E23, 64'h0, 64'h0000000000000FFC, FMT_S, 64'hFFC);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, handshaked immediate-generation stage for the decode path. It covers every RV32I/RV64I immediate format (I, S, B, U, J), sign-extends to XLEN, and masks shift amounts. It also precomputes the PC-relative target (pc + imm) for branch, jump and AUIPC. It sits between fetch/instruction register and the register-read stage, with a valid/ready handshake and a 2-entry skid buffer so backpressure never drops or duplicates an instruction.

Parameters:
XLEN, 32, datapath width for imm, pc and target; legal values 32 or 64
SIGN_EXT, 1, 1 = architectural sign extension; 0 = zero-extend all immediates (legacy compatibility mode)
SHAMT_W, 5, shift-amount width kept for OP-IMM shifts; 5 when XLEN=32, 6 when XLEN=64

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept an instruction this cycle
in_instr  in  32  raw instruction word
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts output this cycle
out_imm  out  XLEN  generated immediate
out_fmt  out  3  format code (imm_fmt_e)
out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN
out_pc  out  XLEN  PC passthrough
out_illegal  out  1  opcode has no decodable immediate class

Behaviour:
- Reset: clock and reset are one clock clk and synchronous active-high rst. With rst high at an edge: both skid entries invalid, out_valid=0, in_ready=1 on the next cycle, and out_imm/out_target/out_pc/out_fmt/out_illegal=0. An in-flight or buffered entry is discarded. No handshake is honoured in the cycle rst is high.
- Transfers: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Latency: 1 cycle from input transfer to out_valid when the buffer is empty. Throughput is 1 per cycle with out_ready held high.
- Storage: 2-entry skid buffer with states EMPTY, ONE, FULL.
  - in_ready = (state != FULL), driven from a register with no combinational path from out_ready.
  - EMPTY: in xfer -> ONE.
  - ONE: in xfer without out xfer -> FULL; out xfer without in xfer -> EMPTY; both -> ONE.
  - FULL: out xfer -> ONE. No input is accepted in FULL.
- Ordering: strict FIFO. The output always presents the oldest entry. Outputs stay stable while out_valid && !out_ready.
- Decode (opcode = instr[6:0]), computed before the buffer write:
  - I-type (0010011 OP-IMM, 0000011 LOAD, 1100111 JALR, 1110011 SYSTEM): imm = ext(instr[31:20]).
  - OP-IMM with funct3 001 or 101: imm = zero-extended instr[20+SHAMT_W-1:20]. funct7/funct6 bits are excluded.
  - S-type (0100011): imm = ext({instr[31:25], instr[11:7]}).
  - B-type (1100011): imm = ext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U-type (0110111 LUI, 0010111 AUIPC): imm = ext({instr[31:12], 12'h0}). When XLEN=64, bits above 31 are sign-extended regardless of SIGN_EXT.
  - J-type (1101111): imm = ext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R-type (0110011): fmt=NONE, imm=0, illegal=0.
  - Any other opcode: fmt=NONE, imm=0, illegal=1.
- ext() sign-extends to XLEN when SIGN_EXT=1 and zero-extends when SIGN_EXT=0.
- out_target = pc + imm for every entry, wrapping modulo 2^XLEN. Consumers use it only for B, J and AUIPC.

Decomposition:
- Shared package imm_pkg:
  - imm_fmt_e (3 bits): NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6.
  - Opcode localparams: OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_OP.
  - Packed struct imm_entry_t {imm, fmt, target, pc, illegal}.
- Sub-module imm_decode: purely combinational (instr, pc) -> imm_entry_t, parametrised by XLEN/SIGN_EXT/SHAMT_W.
- imm_gen_stage instantiates imm_decode and owns the skid FSM and the two imm_entry_t registers.

Test Plan:
- Formats, XLEN=32, SIGN_EXT=1, in_pc=0x1000, out_ready=1:
  - 0xFFF00093 -> imm 0xFFFFFFFF, fmt I
  - 0xFE112E23 -> imm 0xFFFFFFFC, fmt S
  - 0xFE000CE3 -> imm 0xFFFFFFF8, fmt B, target 0x00000FF8
  - 0x123450B7 -> imm 0x12345000, fmt U
  - 0x0080006F -> imm 0x00000008, fmt J, target 0x1008
  - each out_valid exactly 1 cycle after its input transfer
- Shifts: 0x00509093 -> imm 5, fmt SHAMT; 0x4030D093 -> imm 3 (funct7 masked). Opcode 0x7F -> illegal=1, imm 0.
- Backpressure: stream 4 instructions with out_ready=0 -> in_ready drops after 2 accepted, outputs held stable. Release out_ready -> all 4 emerge in order, none lost or duplicated.
- Simultaneous: state ONE with in and out transfers in the same cycle -> state stays ONE, next output is the newer entry.
- Reset mid-operation: FULL state, assert rst 1 cycle -> next cycle out_valid=0, in_ready=1, all outputs 0, old entries never appear.
- Params: XLEN=64, SIGN_EXT=0 with 0xFFF00093 -> imm 0x0000000000000FFF. XLEN=64 LUI 0x800000B7 -> imm 0xFFFFFFFF80000000.
